// File: rtl/sr_latch_driver.sv
// ============================================================================
// Module   : sr_latch_driver
// Brief    : Guarded, glitch-free pulse driver for an external active-low SR
//            latch. Optional readback check enabled by macro READBACK_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_driver #(
  parameter int GUARD_CYCLES   = 2,
  parameter int PULSE_WIDTH    = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic data,
  output logic s_n,
  output logic r_n,
  output logic busy,
  output logic ack,
  input  logic q_fb,
  input  logic clr_err,
  output logic err
);

  localparam logic [7:0] c_guard_load   = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] c_pulse_load   = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] c_recover_load = 8'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GUARD   = 3'd1,
    PULSE   = 3'd2,
    RECOVER = 3'd3,
`ifdef READBACK_CHECK_EN
    CHECK   = 3'd4,
`endif
    DONE    = 3'd5
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_data, w_data_nxt;
  logic       r_s_n, r_r_n, r_busy, r_ack;
  logic       w_s_n_nxt, w_r_n_nxt, w_busy_nxt, w_ack_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_data  <= 1'b0;
      r_s_n   <= 1'b1;
      r_r_n   <= 1'b1;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_s_n   <= w_s_n_nxt;
      r_r_n   <= w_r_n_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_state_nxt = GUARD;
          w_cnt_nxt   = c_guard_load;
          w_data_nxt  = data;
        end
      end
      GUARD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = c_pulse_load;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      PULSE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = c_recover_load;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      RECOVER: begin
        if (r_cnt == 8'd0) begin
`ifdef READBACK_CHECK_EN
          w_state_nxt = CHECK;
`else
          w_state_nxt = DONE;
`endif
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
`ifdef READBACK_CHECK_EN
      CHECK: begin
        w_state_nxt = DONE;
      end
`endif
      DONE: begin
        // The DONE exit edge doubles as the IDLE sampling edge, so a held REQ
        // restarts back-to-back with G+P+R+1 (or +2) spacing.
        if (req) begin
          w_state_nxt = GUARD;
          w_cnt_nxt   = c_guard_load;
          w_data_nxt  = data;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so the pins
    // come straight from flops and only one of them can ever be low.
    w_s_n_nxt  = !((w_state_nxt == PULSE) &&  w_data_nxt);
    w_r_n_nxt  = !((w_state_nxt == PULSE) && !w_data_nxt);
    w_busy_nxt = (w_state_nxt != IDLE);
    w_ack_nxt  = (w_state_nxt == DONE);
  end

  assign s_n  = r_s_n;
  assign r_n  = r_r_n;
  assign busy = r_busy;
  assign ack  = r_ack;

`ifdef READBACK_CHECK_EN
  logic r_q_meta, r_q_sync, r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_meta <= 1'b0;
      r_q_sync <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_q_meta <= q_fb;
      r_q_sync <= r_q_meta;
      // A fresh mismatch takes priority over a simultaneous clear.
      if ((r_state == CHECK) && (r_q_sync != r_data)) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_inputs;
  assign w_unused_inputs = &{1'b0, q_fb, clr_err};
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
// ============================================================================
// Module   : tb_sr_latch_driver
// Brief    : Directed self-checking bench for sr_latch_driver (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_driver;

  logic clk, rst_n, req, data, q_fb, clr_err;
  logic s_n, r_n, busy, ack, err;
  int   total = 0;
  int   bad   = 0;
  int   q_mode = 0;   // 0: Q_FB stuck at 0, 1: Q_FB follows the latch drives
  int   ack_run = 0;

  sr_latch_driver #(
    .GUARD_CYCLES   (2),
    .PULSE_WIDTH    (4),
    .RECOVER_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data    (data),
    .s_n     (s_n),
    .r_n     (r_n),
    .busy    (busy),
    .ack     (ack),
    .q_fb    (q_fb),
    .clr_err (clr_err),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural latch feeding Q_FB
  always @(posedge clk) begin
    #2;
    if (q_mode == 0)  q_fb = 1'b0;
    else if (!s_n)    q_fb = 1'b1;
    else if (!r_n)    q_fb = 1'b0;
  end

  // Continuous safety monitors
  always @(negedge clk) begin
    check("excl_s_r", {31'd0, (!s_n && !r_n)}, 32'd0);
    ack_run = ack ? ack_run + 1 : 0;
    check("ack_len", {31'd0, (ack_run > 1)}, 32'd0);
  end

  // One transaction; bit k of each vector is the output during cycle k,
  // where edge 0 is the edge that accepts REQ.
  task automatic run_txn(input logic d, input int req2_cyc, input int dtog_cyc,
                         input logic clr_hold,
                         output logic [11:0] sv, output logic [11:0] rv,
                         output logic [11:0] av, output logic [11:0] bv,
                         output logic [11:0] ev);
    @(negedge clk);
    req = 1'b1;
    data = d;
    clr_err = clr_hold;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      sv[k] = s_n; rv[k] = r_n; av[k] = ack; bv[k] = busy; ev[k] = err;
      req = (k == req2_cyc);
      if (k == dtog_cyc) data = ~d;
    end
    req = 1'b0;
    clr_err = 1'b0;
  endtask

`ifdef READBACK_CHECK_EN
  localparam logic [11:0] c_ack_exp  = 12'h200;
  localparam logic [11:0] c_busy_exp = 12'h3FF;
`else
  localparam logic [11:0] c_ack_exp  = 12'h100;
  localparam logic [11:0] c_busy_exp = 12'h1FF;
`endif

  logic [11:0] sv, rv, av, bv, ev;
  logic        seen_ack, seen_busy;

  initial begin
    rst_n = 1'b0; req = 1'b0; data = 1'b0; clr_err = 1'b0; q_fb = 1'b0;
    #12;
    check("rst_s_n",  {31'd0, s_n},  32'd1);
    check("rst_r_n",  {31'd0, r_n},  32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack",  {31'd0, ack},  32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write 1
    run_txn(1'b1, -1, -1, 1'b0, sv, rv, av, bv, ev);
    check("w1_s_n",  {20'd0, sv}, {20'd0, 12'hFC3});
    check("w1_r_n",  {20'd0, rv}, {20'd0, 12'hFFF});
    check("w1_ack",  {20'd0, av}, {20'd0, c_ack_exp});
    check("w1_busy", {20'd0, bv}, {20'd0, c_busy_exp});

    // Write 0, DATA toggled mid-pulse
    run_txn(1'b0, -1, 3, 1'b0, sv, rv, av, bv, ev);
    check("w0_s_n",  {20'd0, sv}, {20'd0, 12'hFFF});
    check("w0_r_n",  {20'd0, rv}, {20'd0, 12'hFC3});
    check("w0_ack",  {20'd0, av}, {20'd0, c_ack_exp});
    check("w0_busy", {20'd0, bv}, {20'd0, c_busy_exp});

    // Second REQ while busy is ignored
    run_txn(1'b1, 3, -1, 1'b0, sv, rv, av, bv, ev);
    check("rq2_s_n",  {20'd0, sv}, {20'd0, 12'hFC3});
    check("rq2_r_n",  {20'd0, rv}, {20'd0, 12'hFFF});
    check("rq2_ack",  {20'd0, av}, {20'd0, c_ack_exp});
    check("rq2_busy", {20'd0, bv}, {20'd0, c_busy_exp});

    // Asynchronous reset in the middle of the pulse
    @(negedge clk);
    req = 1'b1; data = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_s_n", {31'd0, s_n}, 32'd0);
    #4 rst_n = 1'b0;
    #1;
    check("mid_rst_s_n",  {31'd0, s_n},  32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ack",  {31'd0, ack},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_ack = 1'b0;
    seen_busy = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      seen_ack  = seen_ack | ack;
      seen_busy = seen_busy | busy;
    end
    check("post_rst_no_ack",  {31'd0, seen_ack},  32'd0);
    check("post_rst_no_busy", {31'd0, seen_busy}, 32'd0);
    run_txn(1'b1, -1, -1, 1'b0, sv, rv, av, bv, ev);
    check("rw1_s_n",  {20'd0, sv}, {20'd0, 12'hFC3});
    check("rw1_r_n",  {20'd0, rv}, {20'd0, 12'hFFF});
    check("rw1_ack",  {20'd0, av}, {20'd0, c_ack_exp});
    check("rw1_busy", {20'd0, bv}, {20'd0, c_busy_exp});

`ifdef READBACK_CHECK_EN
    // Readback mismatch: Q_FB stuck low while writing 1
    q_mode = 0;
    run_txn(1'b1, -1, -1, 1'b0, sv, rv, av, bv, ev);
    check("mm_ack", {20'd0, av}, {20'd0, 12'h200});
    check("mm_err", {20'd0, ev}, {20'd0, 12'hE00});
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("clr_err", {31'd0, err}, 32'd0);

    // Set wins over a coincident clear, then the clear takes effect
    run_txn(1'b1, -1, -1, 1'b1, sv, rv, av, bv, ev);
    check("setwin_err", {20'd0, ev}, {20'd0, 12'h200});

    // Latch follows the drives: no error
    q_mode = 1;
    run_txn(1'b1, -1, -1, 1'b0, sv, rv, av, bv, ev);
    check("ok_err", {20'd0, ev}, {20'd0, 12'h000});
    check("ok_ack", {20'd0, av}, {20'd0, 12'h200});
`else
    check("err_tied", {20'd0, ev}, {20'd0, 12'h000});
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter GUARD_CYCLES, default 2: cycles both latch inputs held inactive before the pulse (legal range 1..255).
REQ-002 Parameter PULSE_WIDTH, default 4: cycles the selected active-low latch input is held low (legal range 1..255).
REQ-003 Parameter RECOVER_CYCLES, default 2: cycles both inputs held inactive after the pulse (legal range 1..255; minimum 2 when READBACK_CHECK_EN is defined).
REQ-004 The ports SHALL be as follows:
- CLK input 1: single clock, rising edge.
- RST_N input 1: asynchronous, active-low reset.
- REQ input 1: write request, level-sampled only in IDLE.
- DATA input 1: bit to store; 1 means set, 0 means reset.
- S_N output 1: active-low set drive to the latch.
- R_N output 1: active-low reset drive to the latch.
- BUSY output 1: high from acceptance until the ACK cycle inclusive.
- ACK output 1: one-cycle completion strobe.
- Q_FB input 1: asynchronous latch Q feedback (used only with the macro).
- CLR_ERR input 1: synchronous clear of ERR (used only with the macro).
- ERR output 1: sticky readback mismatch flag (tied 0 without the macro).

Function
REQ-005 The state machine SHALL have states IDLE, GUARD, PULSE, RECOVER, CHECK (macro only) and DONE, with one shared 8-bit down-counter.
REQ-006 IDLE: when REQ=1 at edge n, the block SHALL capture DATA, set BUSY, and enter GUARD with the counter loaded to GUARD_CYCLES-1.
REQ-007 GUARD SHALL hold S_N=R_N=1 for exactly GUARD_CYCLES cycles, then enter PULSE.
REQ-008 PULSE SHALL drive S_N=0 if the captured DATA=1, or R_N=0 if DATA=0, for exactly PULSE_WIDTH cycles, starting at edge n+GUARD_CYCLES.
REQ-009 RECOVER SHALL hold S_N=R_N=1 for exactly RECOVER_CYCLES cycles.
REQ-010 DONE SHALL assert ACK for exactly one cycle, starting at edge n+G+P+R without the macro or n+G+P+R+1 with it, then return to IDLE with BUSY=0.
REQ-011 S_N, R_N, ACK and BUSY SHALL be driven directly from flops, with no combinational glitches.
REQ-012 S_N and R_N SHALL never be low in the same cycle, in any state or reset sequence.
REQ-013 REQ and DATA changes SHALL be ignored while BUSY=1; there is no queuing.
REQ-014 When REQ is held high continuously, the next transaction SHALL be accepted at the first edge in IDLE after DONE, so transactions are spaced G+P+R+1 (or +2 with the macro) cycles apart.
REQ-015 The counter SHALL never wrap: each state exits when the counter equals 0 and reloads on entry to the next state.

Reset
REQ-016 RST_N=0 SHALL asynchronously force IDLE, S_N=1, R_N=1, BUSY=0, ACK=0, ERR=0, counter=0, captured DATA=0, and clear the synchronizer flops.
REQ-017 If reset is asserted mid-PULSE, the active latch input SHALL return high immediately without waiting for a clock, and no ACK SHALL follow.
REQ-018 After RST_N deasserts, the first REQ SHALL be sampled at the first rising CLK edge.

Configuration
REQ-019 Macro READBACK_CHECK_EN defined: Q_FB SHALL pass through a 2-flop synchronizer, and state CHECK (one cycle, after RECOVER) SHALL compare the synchronized Q_FB to the captured DATA.
REQ-020 On mismatch in CHECK, ERR SHALL set, remain set until CLR_ERR=1 at an edge, and the set SHALL win if it coincides with CLR_ERR.
REQ-021 Macro not defined: CHECK, the synchronizer and the ERR flop SHALL be absent, ERR SHALL be tied to 0, and Q_FB and CLR_ERR SHALL be unused.

Verification
REQ-022 Defaults, no macro, REQ=1 and DATA=1 at edge 0 -> S_N low during cycles 2..5, R_N always 1, ACK high in cycle 8 only, BUSY high in cycles 0..8.
REQ-023 Defaults, DATA=0 -> R_N low during cycles 2..5, S_N always 1; DATA toggled during PULSE has no effect.
REQ-024 Second REQ pulse at cycle 3 of a transaction -> ignored; exactly one ACK; outputs identical to REQ-022.
REQ-025 RST_N driven low at cycle 3.5 (mid-PULSE) -> S_N=1 and BUSY=0 before the next edge, no ACK, and a fresh REQ after release behaves as REQ-022.
REQ-026 Macro defined, write 1 with Q_FB held 0 -> ACK in cycle 9, ERR=1 from cycle 9 onward until CLR_ERR; then write 1 with Q_FB following S_N -> ERR stays 0.
REQ-027 All scenarios: an assertion checks that S_N and R_N are never low together, and that ACK never lasts more than one cycle.
